// File: rtl/branch_predictor_pkg.sv
// Shared CPU definitions used by the branch predictor: counter encodings,
// the sequential PC increment and the default table size.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    localparam logic [31:0] PC_INC      = 32'd4;
    localparam int          ENTRIES_DEF = 16;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup, resolve-side update and redirect/statistics bundle between
// the pipeline (master) and the branch predictor (slave).
interface branch_predictor_if;

    logic [31:0] i_if_pc;
    logic        o_pred_taken;
    logic [31:0] o_pred_target;

    logic        i_upd_valid;
    logic [31:0] i_upd_pc;
    logic        i_upd_taken;
    logic [31:0] i_upd_target;
    logic        i_upd_pred_taken;
    logic [31:0] i_upd_pred_target;

    logic        o_redirect;
    logic [31:0] o_redirect_pc;
    logic [15:0] o_br_count;
    logic [15:0] o_mis_count;

    modport master (
        output i_if_pc,
        output i_upd_valid, i_upd_pc, i_upd_taken, i_upd_target,
        output i_upd_pred_taken, i_upd_pred_target,
        input  o_pred_taken, o_pred_target,
        input  o_redirect, o_redirect_pc, o_br_count, o_mis_count
    );

    modport slave (
        input  i_if_pc,
        input  i_upd_valid, i_upd_pc, i_upd_taken, i_upd_target,
        input  i_upd_pred_taken, i_upd_pred_target,
        output o_pred_taken, o_pred_target,
        output o_redirect, o_redirect_pc, o_br_count, o_mis_count
    );

endinterface

// File: rtl/sat_counter2.sv
// Next-state function of a 2-bit saturating direction counter, shared by all
// table entries through the update port.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    // Step toward strongly-taken on taken, toward strongly-not-taken otherwise
    always_comb begin
        ctr_next = ctr;
        case (ctr)
            CTR_SNT: ctr_next = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: ctr_next = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  ctr_next = taken ? CTR_ST  : CTR_WNT;
            CTR_ST:  ctr_next = taken ? CTR_ST  : CTR_WT;
            default: ctr_next = CTR_WNT;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit counters, misprediction
// redirect generation and saturating branch/misprediction statistics.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = ENTRIES_DEF,
    parameter int IDX_W   = $clog2(ENTRIES)
)
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    branch_predictor_if.slave   bp
);

    localparam int TAG_W = 32 - IDX_W - 2;

    logic              valid_r  [ENTRIES];
    logic [TAG_W-1:0]  tag_r    [ENTRIES];
    logic [31:0]       target_r [ENTRIES];
    logic [1:0]        ctr_r    [ENTRIES];

    logic [IDX_W-1:0]  if_idx_s;
    logic [TAG_W-1:0]  if_tag_s;
    logic [IDX_W-1:0]  upd_idx_s;
    logic [TAG_W-1:0]  upd_tag_s;
    logic              pred_hit_s;
    logic              upd_hit_s;
    logic [1:0]        upd_ctr_next_s;
    logic              mispredict_s;
    logic [31:0]       redirect_pc_next_s;

    logic              redirect_r;
    logic [31:0]       redirect_pc_r;
    logic [15:0]       br_count_r;
    logic [15:0]       mis_count_r;

    // Word-aligned PCs: the two low bits never take part in index or tag
    logic              unused_pc_bits_s;
    assign unused_pc_bits_s = ^{bp.i_if_pc[1:0], bp.i_upd_pc[1:0]};

    assign if_idx_s  = bp.i_if_pc[IDX_W+1:2];
    assign if_tag_s  = bp.i_if_pc[31:IDX_W+2];
    assign upd_idx_s = bp.i_upd_pc[IDX_W+1:2];
    assign upd_tag_s = bp.i_upd_pc[31:IDX_W+2];

    // Fetch lookup against the table contents as of the last clock edge
    always_comb begin
        pred_hit_s = 1'b0;
        if (valid_r[if_idx_s] && (tag_r[if_idx_s] == if_tag_s)) begin
            pred_hit_s = 1'b1;
        end else begin
            pred_hit_s = 1'b0;
        end
    end

    assign bp.o_pred_taken  = pred_hit_s & ctr_r[if_idx_s][1];
    assign bp.o_pred_target = target_r[if_idx_s];

    // Resolve-side hit detection for the entry being trained
    always_comb begin
        upd_hit_s = 1'b0;
        if (valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s)) begin
            upd_hit_s = 1'b1;
        end else begin
            upd_hit_s = 1'b0;
        end
    end

    sat_counter2 u_sat_counter2 (
        .ctr      (ctr_r[upd_idx_s]),
        .taken    (bp.i_upd_taken),
        .ctr_next (upd_ctr_next_s)
    );

    // Misprediction: wrong direction, or right "taken" direction with a stale target
    always_comb begin
        mispredict_s       = 1'b0;
        redirect_pc_next_s = bp.i_upd_pc + PC_INC;
        if (bp.i_upd_valid &&
            ((bp.i_upd_taken != bp.i_upd_pred_taken) ||
             (bp.i_upd_taken && (bp.i_upd_target != bp.i_upd_pred_target)))) begin
            mispredict_s = 1'b1;
        end else begin
            mispredict_s = 1'b0;
        end
        if (bp.i_upd_taken) begin
            redirect_pc_next_s = bp.i_upd_target;
        end else begin
            redirect_pc_next_s = bp.i_upd_pc + PC_INC;
        end
    end

    // Table training: counter/target update on hit, allocation on taken miss
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= '0;
                target_r[i] <= 32'h0000_0000;
                ctr_r[i]    <= CTR_WNT;
            end
        end else if (bp.i_upd_valid) begin
            if (upd_hit_s) begin
                ctr_r[upd_idx_s] <= upd_ctr_next_s;
                if (bp.i_upd_taken) begin
                    target_r[upd_idx_s] <= bp.i_upd_target;
                end
            end else if (bp.i_upd_taken) begin
                valid_r[upd_idx_s]  <= 1'b1;
                tag_r[upd_idx_s]    <= upd_tag_s;
                target_r[upd_idx_s] <= bp.i_upd_target;
                ctr_r[upd_idx_s]    <= CTR_WT;
            end
        end
    end

    // One-cycle redirect pulse; the redirect PC holds between pulses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            redirect_r    <= 1'b0;
            redirect_pc_r <= 32'h0000_0000;
        end else begin
            redirect_r <= mispredict_s;
            if (mispredict_s) begin
                redirect_pc_r <= redirect_pc_next_s;
            end
        end
    end

    // Saturating statistics counters
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            br_count_r  <= 16'h0000;
            mis_count_r <= 16'h0000;
        end else begin
            if (bp.i_upd_valid && (br_count_r != 16'hFFFF)) begin
                br_count_r <= br_count_r + 16'd1;
            end
            if (mispredict_s && (mis_count_r != 16'hFFFF)) begin
                mis_count_r <= mis_count_r + 16'd1;
            end
        end
    end

    assign bp.o_redirect    = redirect_r;
    assign bp.o_redirect_pc = redirect_pc_r;
    assign bp.o_br_count    = br_count_r;
    assign bp.o_mis_count   = mis_count_r;

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ENTRIES, 16, number of direct-mapped table entries; power of two, 4..64.
REQ-002 Parameter IDX_W, log2(ENTRIES), index width; the index is pc[IDX_W+1:2] and the tag is pc[31:IDX_W+2].
REQ-003 i_clk  input  1  single clock; all state changes on the rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous and active-low.
REQ-005 i_if_pc  input  32  fetch-stage PC to predict.
REQ-006 o_pred_taken  output  1  prediction for i_if_pc; 1 means taken.
REQ-007 o_pred_target  output  32  predicted target; valid only when o_pred_taken=1.
REQ-008 i_upd_valid  input  1  a resolved branch is presented this cycle.
REQ-009 i_upd_pc  input  32  PC of the resolved branch.
REQ-010 i_upd_taken  input  1  actual outcome from the branch comparator (o_branch).
REQ-011 i_upd_target  input  32  actual branch target.
REQ-012 i_upd_pred_taken, i_upd_pred_target  input  1/32  prediction carried down the pipe with this branch.
REQ-013 o_redirect  output  1  one-cycle pulse to flush the front end and reload the PC.
REQ-014 o_redirect_pc  output  32  PC to load when o_redirect=1.
REQ-015 o_br_count, o_mis_count  output  16/16  saturating counts of resolved branches and mispredictions.

Function
REQ-016 Each entry SHALL hold: valid (1 bit), tag, target (32 bits) and a 2-bit saturating counter.
REQ-017 Lookup SHALL be combinational: o_pred_taken = valid & tag match & ctr[1]; o_pred_target = the entry target.
REQ-018 Table writes SHALL take effect at the clock edge. A same-cycle lookup of the entry being updated SHALL return the pre-update contents.
REQ-019 Update on a hit (i_upd_valid, valid, tag match) SHALL apply:
- taken: ctr+1, saturating at 3; target overwritten with i_upd_target.
- not taken: ctr-1, saturating at 0.
REQ-020 Update on a miss with i_upd_taken=1 SHALL allocate the entry, overwriting any occupant: valid=1, new tag and target, ctr=2'b10.
REQ-021 An update on a miss with i_upd_taken=0 SHALL leave the table unchanged.
REQ-022 A misprediction SHALL be: i_upd_valid & (i_upd_taken != i_upd_pred_taken | (i_upd_taken & i_upd_target != i_upd_pred_target)).
REQ-023 On a misprediction, the following cycle SHALL have:
- o_redirect=1 for exactly one cycle.
- o_redirect_pc = i_upd_target when taken, otherwise i_upd_pc+4 (mod 2^32).
REQ-024 When o_redirect=0, o_redirect_pc SHALL hold its last value.
REQ-025 o_br_count SHALL increment on every i_upd_valid; o_mis_count SHALL increment on every misprediction. Both SHALL saturate at 16'hFFFF without wrapping.
REQ-026 Mispredictions on back-to-back cycles SHALL produce back-to-back o_redirect pulses, each carrying its own PC.

Reset
REQ-027 Asserting i_rst_n=0 SHALL immediately clear all valid bits, set counters to 2'b01, and zero o_redirect, o_redirect_pc, o_br_count and o_mis_count.
REQ-028 A reset asserted mid-operation SHALL discard any pending redirect; no pulse is issued after reset release.
REQ-029 With the table empty after reset, o_pred_taken SHALL be 0 for every PC.

Structure
REQ-030 The shared CPU package SHALL hold: counter encodings (SNT=00, WNT=01, WT=10, ST=11), the PC increment constant 4, and the ENTRIES default.
REQ-031 The 2-bit saturating counter update SHALL be one sub-module, sat_counter2, instantiated per entry or as a single shared next-state function; all other logic stays in branch_predictor.

Verification
REQ-032 After reset, i_if_pc=0x0000_0040 -> o_pred_taken=0; o_redirect=0; both counts 0.
REQ-033 Update pc=0x40, taken=1, target=0x100, pred_taken=0:
- next cycle: o_redirect=1, o_redirect_pc=0x100, o_mis_count=1.
- i_if_pc=0x40 then gives o_pred_taken=1, o_pred_target=0x100.
REQ-034 Two not-taken updates to pc=0x40 (counter WT->WNT->SNT):
- o_pred_taken=0 after the first update.
- o_redirect_pc=0x44 on each mispredicted update.
REQ-035 Aliasing: entry allocated for pc=0x40, then a taken update for pc=0x80 (ENTRIES=16, same index 0) -> lookup of 0x40 gives o_pred_taken=0; lookup of 0x80 gives o_pred_taken=1.
REQ-036 Same-cycle lookup and update of pc=0x40 -> lookup returns the old counter value; the new value is visible one cycle later.
REQ-037 Counter saturation: force o_br_count to 0xFFFF, then one more update -> o_br_count stays 0xFFFF. Separately, assert i_rst_n=0 during a redirect cycle -> o_redirect drops immediately.
